// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 8;
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_Q = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/seq_div16by8_if.sv
// Operand/result handshake bundle for seq_div16by8 (valid/ready on both sides).
interface seq_div16by8_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial = {rem, din};
  assign diff  = trial - {1'b0, divisor};

  // With rem < divisor the trial is below 2*divisor, so the difference fits WIDTH bits.
  always_comb begin
    q_bit    = 1'b0;
    rem_next = trial[WIDTH-1:0];
    if (trial >= {1'b0, divisor}) begin
      q_bit    = 1'b1;
      rem_next = diff[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/seq_div16by8.sv
// Iterative restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient + remainder, one bit per clock.
// Optional DIV_EARLY_OVF_EN: overflowing operands skip the step loop and finish in one cycle.
module seq_div16by8
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_div16by8_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_t        state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  d_r;
  logic [WIDTH-1:0]  l_r;
  logic [WIDTH-1:0]  r_r;
  logic [WIDTH-1:0]  q_r;
  logic              ovf_pend;

  logic [WIDTH-1:0]  quotient_r;
  logic [WIDTH-1:0]  remainder_r;
  logic              ovf_r;
  logic              out_valid_r;

  logic [WIDTH-1:0]  r_next;
  logic              q_bit;
  logic              accept;
  logic              acc_ovf;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.ovf       = ovf_r;

  assign accept  = bus.in_valid && (state == IDLE);
  // Divisor of zero falls out naturally: any high half is >= 0.
  assign acc_ovf = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_r),
    .din      (l_r[cnt]),
    .divisor  (d_r),
    .rem_next (r_next),
    .q_bit    (q_bit)
  );

  // NOTE: every register here is written with <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      d_r         <= '0;
      l_r         <= '0;
      r_r         <= '0;
      q_r         <= '0;
      ovf_pend    <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            d_r      <= bus.divisor;
            l_r      <= bus.dividend[WIDTH-1:0];
            r_r      <= bus.dividend[2*WIDTH-1:WIDTH];
            q_r      <= '0;
            ovf_pend <= acc_ovf;
            cnt      <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_OVF_EN
            if (acc_ovf) begin
              state       <= DONE;
              quotient_r  <= '1;
              remainder_r <= '0;
              ovf_r       <= 1'b1;
              out_valid_r <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end

        RUN: begin
          r_r <= r_next;
          q_r <= {q_r[WIDTH-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            ovf_r       <= ovf_pend;
            quotient_r  <= ovf_pend ? '1 : {q_r[WIDTH-2:0], q_bit};
            remainder_r <= ovf_pend ? '0 : r_next;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div16by8.sv
// Scoreboard bench for seq_div16by8: directed cases, hold/take, mid-run reset, random sweep.
module tb_seq_div16by8;
  import div_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             ovf;
    int               lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;
  exp_t sb[$];

  seq_div16by8_if #(.WIDTH(WIDTH)) bus ();

  seq_div16by8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    if (b == 0 || a[2*WIDTH-1:WIDTH] >= b) begin
      e.q   = DIV_OVF_Q;
      e.r   = '0;
      e.ovf = 1'b1;
`ifdef DIV_EARLY_OVF_EN
      e.lat = 1;
`else
      e.lat = WIDTH;
`endif
    end else begin
      e.q   = WIDTH'(a / {8'd0, b});
      e.r   = WIDTH'(a % {8'd0, b});
      e.ovf = 1'b0;
      e.lat = WIDTH;
    end
    return e;
  endfunction

  // Waits (bounded) for in_ready, drives one operation and returns after the accept edge.
  task automatic issue(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
  endtask

  // Full transaction: issue, measure latency, compare against scoreboard, hold, take.
  task automatic do_op(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(a, b));
    issue(a, b);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat < WIDTH && !bus.out_valid) begin
        bus.in_valid = 1'b1;   // must be ignored while busy
        bus.dividend = 16'($urandom);
      end
    end while (!bus.out_valid && lat < 50);
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("quotient", 32'(bus.quotient), 32'(e.q));
    check("remainder", 32'(bus.remainder), 32'(e.r));
    check("ovf", 32'(bus.ovf), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_q", 32'(bus.quotient), 32'(e.q));
      check("hold_r", 32'(bus.remainder), 32'(e.r));
      check("hold_ovf", 32'(bus.ovf), 32'(e.ovf));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("take_valid", 32'(bus.out_valid), 32'd0);
    check("take_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int stale;
    errs          = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 8'h56, 0);
    do_op(16'hFEFF, 8'hFF, 0);
    do_op(16'h0005, 8'h00, 0);
    do_op(16'hFF00, 8'hFF, 0);
    do_op(16'h1234, 8'h56, 5);

    // Reset part-way through an operation: nothing may emerge afterwards.
    issue(16'h1234, 8'h56);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_q", 32'(bus.quotient), 32'd0);
    check("midrst_r", 32'(bus.remainder), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);

    do_op(16'h0000, 8'h01, 0);
    do_op(16'h00FF, 8'h10, 0);

    for (int k = 0; k < 24; k++) begin
      logic [WIDTH-1:0] b;
      logic [2*WIDTH-1:0] a;
      b = 8'($urandom_range(0, 255));
      a = 16'($urandom);
      if (k % 3 != 0 && b != 0) a[15:8] = 8'($urandom_range(0, int'(b) - 1));
      do_op(a, b, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
